// File: rtl/data_cache_ctrl.sv
// Set-associative L1 data-cache tag/state controller (write-back, write-allocate, true LRU).
// Define DC_STATS_EN to implement the hit/miss/read/write counters; otherwise they read as zero.
module data_cache_ctrl #(
    parameter int SETS     = 16384,
    parameter int WAYS     = 4,
    parameter int ADDRBITS = 32,
    parameter int OFFBITS  = 6,
    parameter int IDXBITS  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_op,
    input  logic [ADDRBITS-1:0]          cmd_addr,
    output logic                         rsp_valid,
    output logic                         rsp_hit,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [1:0]                   mem_cmd,
    output logic [ADDRBITS-OFFBITS-1:0]  mem_addr,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt,
    output logic [31:0]                  read_cnt,
    output logic [31:0]                  write_cnt,
    output logic [2:0]                   dbg_state
);

    localparam int TAGBITS  = ADDRBITS - IDXBITS - OFFBITS;
    localparam int LINEBITS = ADDRBITS - OFFBITS;
    localparam int AGEW     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AGEW-1:0] AGE_MAX = AGEW'(WAYS - 1);

    localparam logic [3:0] OP_RD  = 4'd0;
    localparam logic [3:0] OP_WR  = 4'd1;
    localparam logic [3:0] OP_INV = 4'd3;
    localparam logic [3:0] OP_CLR = 4'd8;

    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WB   = 2'b10;
    localparam logic [1:0] MEM_RWIM = 2'b11;

    typedef logic [WAYS-1:0][AGEW-1:0]    ages_t;
    typedef logic [WAYS-1:0][TAGBITS-1:0] tags_t;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_WB     = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a next-level request transfers on a rising edge where mem_valid && mem_ready, and
    // mem_valid/mem_cmd/mem_addr never change while mem_valid is high and mem_ready is low.

    state_t               state_q;
    logic [3:0]           op_q;
    logic [LINEBITS-1:0]  line_q;
    logic [IDXBITS-1:0]   clr_idx_q;
    logic                 clr_rsp_q;
    logic [AGEW-1:0]      victim_q;
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_hit_q;
    logic                 mem_valid_q;
    logic [1:0]           mem_cmd_q;
    logic [LINEBITS-1:0]  mem_addr_q;

    tags_t                tag_q   [SETS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    ages_t                age_q   [SETS];

    logic [IDXBITS-1:0]   set_idx;
    logic [TAGBITS-1:0]   req_tag;
    tags_t                row_tag;
    logic [WAYS-1:0]      row_valid;
    logic [WAYS-1:0]      row_dirty;
    ages_t                row_age;
    ages_t                init_ages;
    logic                 hit;
    logic [AGEW-1:0]      hit_way;
    logic [AGEW-1:0]      victim;
    logic                 victim_found;
    logic [1:0]           fill_cmd;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[OFFBITS-1:0];

    assign set_idx   = line_q[IDXBITS-1:0];
    assign req_tag   = line_q[LINEBITS-1:IDXBITS];
    assign row_tag   = tag_q[set_idx];
    assign row_valid = valid_q[set_idx];
    assign row_dirty = dirty_q[set_idx];
    assign row_age   = age_q[set_idx];
    assign fill_cmd  = (op_q == OP_WR) ? MEM_RWIM : MEM_RD;

    // Way w becomes MRU; every way that was younger than it ages by one.
    function automatic ages_t promote(input ages_t a, input logic [AGEW-1:0] t);
        ages_t r;
        r = a;
        for (int w = 0; w < WAYS; w++) begin
            if (a[w] < a[t]) r[w] = a[w] + AGEW'(1);
        end
        r[t] = '0;
        return r;
    endfunction

    // Way w becomes LRU; every way that was older than it moves one step younger.
    function automatic ages_t demote(input ages_t a, input logic [AGEW-1:0] t);
        ages_t r;
        r = a;
        for (int w = 0; w < WAYS; w++) begin
            if (a[w] > a[t]) r[w] = a[w] - AGEW'(1);
        end
        r[t] = AGE_MAX;
        return r;
    endfunction

    always_comb begin
        init_ages    = '0;
        hit          = 1'b0;
        hit_way      = '0;
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            init_ages[w] = AGEW'(w);
            if (row_valid[w] && (row_tag[w] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = AGEW'(w);
            end
            if (!row_valid[w] && !victim_found) begin
                victim       = AGEW'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (row_age[w] == AGE_MAX) victim = AGEW'(w);
            end
        end
    end

    // Tag/state arrays carry no reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        case (state_q)
            S_CLEAR: begin
                valid_q[clr_idx_q] <= '0;
                dirty_q[clr_idx_q] <= '0;
                age_q[clr_idx_q]   <= init_ages;
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (op_q == OP_INV) begin
                        valid_q[set_idx][hit_way] <= 1'b0;
                        dirty_q[set_idx][hit_way] <= 1'b0;
                        age_q[set_idx]            <= demote(row_age, hit_way);
                    end else begin
                        age_q[set_idx] <= promote(row_age, hit_way);
                        if (op_q == OP_WR) dirty_q[set_idx][hit_way] <= 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    tag_q[set_idx][victim_q]   <= req_tag;
                    valid_q[set_idx][victim_q] <= 1'b1;
                    dirty_q[set_idx][victim_q] <= (op_q == OP_WR);
                    age_q[set_idx]             <= promote(row_age, victim_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            op_q        <= '0;
            line_q      <= '0;
            clr_idx_q   <= '0;
            clr_rsp_q   <= 1'b0;
            victim_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_cmd_q   <= '0;
            mem_addr_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDXBITS'(1);
                    if (clr_idx_q == IDXBITS'(SETS - 1)) begin
                        clr_idx_q <= '0;
                        clr_rsp_q <= 1'b0;
                        if (clr_rsp_q) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_hit_q   <= 1'b0;
                        end else begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        line_q      <= cmd_addr[ADDRBITS-1:OFFBITS];
                        case (cmd_op)
                            OP_RD, OP_WR, OP_INV: state_q <= S_LOOKUP;
                            OP_CLR: begin
                                state_q   <= S_CLEAR;
                                clr_idx_q <= '0;
                                clr_rsp_q <= 1'b1;
                            end
                            default: begin
                                state_q     <= S_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_hit_q   <= 1'b0;
                            end
                        endcase
                    end
                end
                S_LOOKUP: begin
                    if (hit || (op_q == OP_INV)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= hit;
                    end else begin
                        victim_q    <= victim;
                        mem_valid_q <= 1'b1;
                        if (row_valid[victim] && row_dirty[victim]) begin
                            state_q    <= S_WB;
                            mem_cmd_q  <= MEM_WB;
                            mem_addr_q <= {row_tag[victim], set_idx};
                        end else begin
                            state_q    <= S_FILL;
                            mem_cmd_q  <= fill_cmd;
                            mem_addr_q <= line_q;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        state_q    <= S_FILL;
                        mem_cmd_q  <= fill_cmd;
                        mem_addr_q <= line_q;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        state_q     <= S_RESP;
                        mem_valid_q <= 1'b0;
                        mem_cmd_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

`ifdef DC_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] read_cnt_q;
    logic [31:0] write_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else if (state_q == S_IDLE && cmd_valid && cmd_ready_q && cmd_op == OP_CLR) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else if (state_q == S_LOOKUP && (op_q == OP_RD || op_q == OP_WR)) begin
            if (op_q == OP_RD) read_cnt_q  <= sat_inc(read_cnt_q);
            else               write_cnt_q <= sat_inc(write_cnt_q);
            if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else     miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign read_cnt  = read_cnt_q;
    assign write_cnt = write_cnt_q;
`else
    assign hit_cnt   = 32'h0;
    assign miss_cnt  = 32'h0;
    assign read_cnt  = 32'h0;
    assign write_cnt = 32'h0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign mem_valid = mem_valid_q;
    assign mem_cmd   = mem_cmd_q;
    assign mem_addr  = mem_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl at SETS=4, WAYS=2; counter expectations follow DC_STATS_EN.
module tb_data_cache_ctrl;

    localparam int SETS     = 4;
    localparam int WAYS     = 2;
    localparam int ADDRBITS = 32;
    localparam int OFFBITS  = 6;
    localparam int IDXBITS  = 2;

`ifdef DC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        cmd_valid = 1'b0;
    logic                        cmd_ready;
    logic [3:0]                  cmd_op = '0;
    logic [ADDRBITS-1:0]         cmd_addr = '0;
    logic                        rsp_valid;
    logic                        rsp_hit;
    logic                        mem_valid;
    logic                        mem_ready = 1'b0;
    logic [1:0]                  mem_cmd;
    logic [ADDRBITS-OFFBITS-1:0] mem_addr;
    logic [31:0]                 hit_cnt, miss_cnt, read_cnt, write_cnt;
    logic [2:0]                  dbg_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    data_cache_ctrl #(
        .SETS(SETS), .WAYS(WAYS), .ADDRBITS(ADDRBITS), .OFFBITS(OFFBITS), .IDXBITS(IDXBITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .read_cnt(read_cnt), .write_cnt(write_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int v);
        return STATS ? 32'(v) : 32'h0;
    endfunction

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] addr);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic serve_mem(input string tag, input logic [1:0] ecmd,
                             input logic [25:0] eaddr, input int stall);
        int n;
        n = 0;
        while (mem_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mvalid"}, 32'(mem_valid), 32'h1);
        check({tag, "_mcmd"}, 32'(mem_cmd), 32'(ecmd));
        check({tag, "_maddr"}, 32'(mem_addr), 32'(eaddr));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(mem_valid), 32'h1);
            check({tag, "_hold_cmd"}, 32'(mem_cmd), 32'(ecmd));
            check({tag, "_hold_addr"}, 32'(mem_addr), 32'(eaddr));
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic exp_hit);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rvalid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_rhit"}, 32'(rsp_hit), 32'(exp_hit));
        @(negedge clk);
        check({tag, "_rpulse"}, 32'(rsp_valid), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and CLEAR sweep length
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'h0);
        check("rst_mvalid", 32'(mem_valid), 32'h0);
        check("rst_rvalid", 32'(rsp_valid), 32'h0);
        check("rst_hitcnt", hit_cnt, 32'h0);
        check("rst_misscnt", miss_cnt, 32'h0);
        check("rst_readcnt", read_cnt, 32'h0);
        check("rst_writecnt", write_cnt, 32'h0);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("clear_ready_low", 32'(cmd_ready), 32'h0);
        end
        @(negedge clk);
        check("clear_ready_high", 32'(cmd_ready), 32'h1);
        check("idle_mvalid", 32'(mem_valid), 32'h0);

        // Read 0x40 twice: miss then hit at accept+2
        issue("rd1", 4'd0, 32'h0000_0040);
        serve_mem("rd1", 2'b01, 26'h1, 0);
        wait_rsp("rd1", 1'b0);
        issue("rd2", 4'd0, 32'h0000_0040);
        check("rd2_lat1", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("rd2_lat2", 32'(rsp_valid), 32'h1);
        check("rd2_hit", 32'(rsp_hit), 32'h1);
        check("rd2_nomem", 32'(mem_valid), 32'h0);
        check("cnt_hit", hit_cnt, ecnt(1));
        check("cnt_miss", miss_cnt, ecnt(1));
        check("cnt_read", read_cnt, ecnt(2));
        check("cnt_write", write_cnt, ecnt(0));

        // Unknown op: response next cycle, no memory traffic
        issue("unk", 4'd2, 32'h0000_0040);
        check("unk_rvalid", 32'(rsp_valid), 32'h1);
        check("unk_rhit", 32'(rsp_hit), 32'h0);
        check("unk_mvalid", 32'(mem_valid), 32'h0);
        check("unk_readcnt", read_cnt, ecnt(2));

        // Clear op: counters zero next cycle, response after sweep, old line gone
        issue("clr", 4'd8, 32'h0);
        check("clr_readcnt", read_cnt, 32'h0);
        check("clr_hitcnt", hit_cnt, 32'h0);
        check("clr_ready", 32'(cmd_ready), 32'h0);
        wait_rsp("clr", 1'b0);
        issue("clr_rd", 4'd0, 32'h0000_0040);
        serve_mem("clr_rd", 2'b01, 26'h1, 0);
        wait_rsp("clr_rd", 1'b0);

        // Three writes to set 1: third evicts the dirty line of 0x040
        do_reset();
        issue("wr1", 4'd1, 32'h0000_0040);
        serve_mem("wr1", 2'b11, 26'h1, 0);
        wait_rsp("wr1", 1'b0);
        issue("wr2", 4'd1, 32'h0000_0140);
        serve_mem("wr2", 2'b11, 26'h5, 0);
        wait_rsp("wr2", 1'b0);
        issue("wr3", 4'd1, 32'h0000_0240);
        serve_mem("wr3_wb", 2'b10, 26'h1, 0);
        serve_mem("wr3_fill", 2'b11, 26'h9, 0);
        wait_rsp("wr3", 1'b0);
        check("wr_writecnt", write_cnt, ecnt(3));
        check("wr_misscnt", miss_cnt, ecnt(3));
        issue("wr4", 4'd0, 32'h0000_0140);
        wait_rsp("wr4", 1'b1);

        // Write, invalidate, read: clean miss without write-back
        do_reset();
        issue("inv_wr", 4'd1, 32'h0000_0040);
        serve_mem("inv_wr", 2'b11, 26'h1, 0);
        wait_rsp("inv_wr", 1'b0);
        issue("inv", 4'd3, 32'h0000_0040);
        check("inv_nomem", 32'(mem_valid), 32'h0);
        @(negedge clk);
        check("inv_rvalid", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        check("inv_writecnt", write_cnt, ecnt(1));
        issue("inv_rd", 4'd0, 32'h0000_0040);
        serve_mem("inv_rd", 2'b01, 26'h1, 0);
        wait_rsp("inv_rd", 1'b0);

        // Stall mem_ready for 10 cycles during FILL
        issue("stall", 4'd0, 32'h0000_0080);
        serve_mem("stall", 2'b01, 26'h2, 10);
        check("stall_rvalid", 32'(rsp_valid), 32'h1);
        check("stall_rhit", 32'(rsp_hit), 32'h0);
        check("stall_mvalid_after", 32'(mem_valid), 32'h0);

        // Reset mid-FILL: request dropped at once, cache emptied
        issue("pre_rd", 4'd0, 32'h0000_0040);
        wait_rsp("pre_rd", 1'b1);
        issue("mid", 4'd0, 32'h0000_00C0);
        begin
            int n;
            n = 0;
            while (mem_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_mvalid", 32'(mem_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mvalid", 32'(mem_valid), 32'h0);
        check("mid_rst_mcmd", 32'(mem_cmd), 32'h0);
        check("mid_rst_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_clear_ready", 32'(cmd_ready), 32'h0);
        issue("post_rd", 4'd0, 32'h0000_0040);
        serve_mem("post_rd", 2'b01, 26'h1, 0);
        wait_rsp("post_rd", 1'b0);
        check("post_misscnt", miss_cnt, ecnt(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
